input_memory_node: RTL

//  Strided read engine feeding one CGRA input column. On start it fetches size_i 32-bit

---
 rtl/input_memory_node_pkg.sv | 16 +
 rtl/input_memory_node_fifo.sv | 38 +++
 rtl/input_memory_node.sv | 81 ++++++++
 3 files changed

// File: rtl/input_memory_node_pkg.sv
// input_memory_node_pkg: FSM state encoding and OBI request/response types for the strided read engine.
package input_memory_node_pkg;
  typedef enum logic [1:0] {S_IMN_IDLE, S_IMN_REQ, S_IMN_DRAIN, S_IMN_DONE} imn_state_t;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/input_memory_node_fifo.sv
// input_memory_node_fifo: first-word fall-through response buffer with occupancy count.
module input_memory_node_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_pop;
  assign do_pop  = pop_i && count != '0;
  assign valid_o = count != '0;
  assign data_o  = mem[rptr];
  assign count_o = count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= data_i;
  end
endmodule

// File: rtl/input_memory_node.sv
// input_memory_node: strided OBI read engine streaming size words from addr, addr+stride, ... to a CGRA column.
module input_memory_node
  import input_memory_node_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] size_i,
  input  logic [15:0] stride_i,
  output obi_req_t    obi_req_o,
  input  obi_resp_t   obi_resp_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  imn_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [15:0] size_q, stride_q, req_cnt, pop_cnt;
  logic [CW-1:0] outstanding, fifo_count;
  logic        credit, gnt_acc, pop, last_req, last_pop, launch;
  // Outstanding plus buffered words never exceeds the FIFO, so every rvalid has a slot.
  assign credit    = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign obi_req_o = '{req: state_q == S_IMN_REQ && credit, we: 1'b0, be: 4'hF,
                       addr: addr_q, wdata: 32'h0};
  assign gnt_acc   = obi_req_o.req && obi_resp_i.gnt;
  assign pop       = valid_o && ready_i;
  assign last_req  = gnt_acc && req_cnt + 16'd1 == size_q;
  assign last_pop  = pop && pop_cnt + 16'd1 == size_q;
  assign launch    = state_q == S_IMN_IDLE && start_i;
  assign busy_o    = state_q != S_IMN_IDLE;
  assign done_o    = state_q == S_IMN_DONE;
  always_comb begin
    state_d = launch                                ? (size_i != '0 ? S_IMN_REQ : S_IMN_DONE) :
              (state_q == S_IMN_REQ   && last_req)  ? S_IMN_DRAIN :
              (state_q == S_IMN_DRAIN && last_pop)  ? S_IMN_DONE :
              (state_q == S_IMN_DONE)               ? S_IMN_IDLE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IMN_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      stride_q    <= '0;
      req_cnt     <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding + CW'(gnt_acc) - CW'(obi_resp_i.rvalid);
      if (launch) begin
        addr_q   <= addr_i;
        size_q   <= size_i;
        stride_q <= stride_i;
        req_cnt  <= '0;
        pop_cnt  <= '0;
      end else begin
        if (gnt_acc) begin
          addr_q  <= addr_q + {16'h0, stride_q};
          req_cnt <= req_cnt + 16'd1;
        end
        if (pop) pop_cnt <= pop_cnt + 16'd1;
      end
    end
  end
  input_memory_node_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (obi_resp_i.rvalid),
    .data_i  (obi_resp_i.rdata),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .count_o (fifo_count)
  );
endmodule
